y86_execute_stage: RTL and testbench

//  Parametrised, registered Y86-64 execute stage: ALU operand select, ALU, condition-code register, Cnd

---
 rtl/y86_pkg.sv | 48 ++++
 rtl/y86_iter_mul.sv | 76 +++++++
 rtl/y86_execute_stage.sv | 195 +++++++++++++++++++
 tb/tb_y86_execute_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute-stage slice: instruction codes,
// status codes, register sentinel, ALU function and branch/move conditions.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_XOR = 3'd3,
    ALU_MUL = 3'd4
  } alu_fn_t;

  typedef enum logic [3:0] {
    C_YES = 4'd0,
    C_LE  = 4'd1,
    C_L   = 4'd2,
    C_E   = 4'd3,
    C_NE  = 4'd4,
    C_GE  = 4'd5,
    C_G   = 4'd6
  } cond_t;

  // Any of these downstream states means the architectural state must freeze.
  function automatic logic stat_exc(input logic [2:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

endpackage

// File: rtl/y86_iter_mul.sv
// Iterative shift-add multiplier: retires MUL_BPC multiplier bits per
// advancing cycle, producing the low DW bits of a*b after DW/MUL_BPC chunks.
// The first chunk is folded into the start cycle; done_o holds until ack_i.
module y86_iter_mul #(
  parameter int unsigned DW      = 64,
  parameter int unsigned MUL_BPC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          adv_i,
  input  logic          ack_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] p_o
);

  localparam int unsigned N  = DW / MUL_BPC;
  localparam int unsigned CW = $clog2(N + 1);

  logic [DW-1:0] acc_q, mc_q, mp_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;

  function automatic logic [DW-1:0] chunk(input logic [DW-1:0] mc,
                                          input logic [DW-1:0] mp);
    logic [DW-1:0] s;
    s = '0;
    for (int unsigned j = 0; j < MUL_BPC; j++)
      if (mp[j]) s = s + (mc << j);
    return s;
  endfunction

  // Accumulate one chunk per advancing cycle; cnt_q counts chunks already summed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mc_q   <= '0;
      mp_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      acc_q <= chunk(a_i, b_i);
      mc_q  <= a_i << MUL_BPC;
      mp_q  <= b_i >> MUL_BPC;
      if (N == 1) begin
        cnt_q  <= '0;
        done_q <= 1'b1;
      end else begin
        cnt_q  <= CW'(1);
        busy_q <= 1'b1;
      end
    end else if (busy_q && adv_i) begin
      acc_q <= acc_q + chunk(mc_q, mp_q);
      mc_q  <= mc_q << MUL_BPC;
      mp_q  <= mp_q >> MUL_BPC;
      if (cnt_q == CW'(N - 1)) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (done_q && ack_i) begin
      done_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_o    = acc_q;

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, Cnd, cmov
// dstE squash and the E->M pipeline register with stall/bubble.
// Optional multi-cycle mulq (OPq ifun 4) when Y86_EXEC_MULQ_EN is defined.
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int unsigned DW      = 64,
  parameter int unsigned MUL_BPC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    E_stat,
  input  logic [3:0]    E_icode,
  input  logic [3:0]    E_ifun,
  input  logic [DW-1:0] E_valA,
  input  logic [DW-1:0] E_valB,
  input  logic [DW-1:0] E_valC,
  input  logic [3:0]    E_dstE,
  input  logic [3:0]    E_dstM,
  input  logic [2:0]    m_stat,
  input  logic [2:0]    W_stat,
  input  logic          M_stall,
  input  logic          M_bubble,
  output logic [DW-1:0] e_valE,
  output logic [3:0]    e_dstE,
  output logic          e_Cnd,
  output logic          e_busy,
  output logic [2:0]    M_stat,
  output logic [3:0]    M_icode,
  output logic          M_Cnd,
  output logic [DW-1:0] M_valE,
  output logic [DW-1:0] M_valA,
  output logic [3:0]    M_dstE,
  output logic [3:0]    M_dstM,
  output logic          cc_zf,
  output logic          cc_sf,
  output logic          cc_of
);

  localparam logic [DW-1:0] POS8 = DW'(8);
  localparam logic [DW-1:0] NEG8 = ~POS8 + DW'(1);

  if (DW < 8 || (DW % MUL_BPC) != 0) begin : g_bad_cfg
    $error("y86_execute_stage: DW must be >= 8 and a multiple of MUL_BPC");
  end

  logic [DW-1:0] aluA, aluB, sum, dif, alu_r;
  logic          alu_of, op_ok, mul_ok, cc_en;
  alu_fn_t       fn;

`ifdef Y86_EXEC_MULQ_EN
  logic          is_mul, mul_busy, mul_done;
  logic [DW-1:0] mul_p;

  assign is_mul = (E_icode == IOPQ) && (E_ifun == 4'd4);

  y86_iter_mul #(.DW(DW), .MUL_BPC(MUL_BPC)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (is_mul && !mul_busy && !mul_done && !M_stall),
    .adv_i   (!M_stall),
    .ack_i   (!M_stall),
    .a_i     (aluA),
    .b_i     (aluB),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  assign e_busy = is_mul && !mul_done;
  assign mul_ok = !is_mul || mul_done;
`else
  assign e_busy = 1'b0;
  assign mul_ok = 1'b1;
`endif

  // Operand selection by instruction class.
  always_comb begin
    aluA = '0;
    aluB = '0;
    unique case (E_icode)
      IRRMOVQ:                aluA = E_valA;
      IOPQ:          begin aluA = E_valA; aluB = E_valB; end
      IIRMOVQ:                aluA = E_valC;
      IRMMOVQ, IMRMOVQ: begin aluA = E_valC; aluB = E_valB; end
      ICALL, IPUSHQ: begin aluA = NEG8;   aluB = E_valB; end
      IRET, IPOPQ:   begin aluA = POS8;   aluB = E_valB; end
      default: ;
    endcase
  end

  // Function decode; unsupported OPq codes yield zero and leave CC alone.
  always_comb begin
    fn    = ALU_ADD;
    op_ok = 1'b1;
    if (E_icode == IOPQ) begin
      if (E_ifun < 4'd4) fn = alu_fn_t'({1'b0, E_ifun[1:0]});
`ifdef Y86_EXEC_MULQ_EN
      else if (E_ifun == 4'd4) fn = ALU_MUL;
`endif
      else op_ok = 1'b0;
    end
  end

  // ALU result and signed-overflow detection.
  always_comb begin
    sum    = aluB + aluA;
    dif    = aluB - aluA;
    alu_r  = '0;
    alu_of = 1'b0;
    case (fn)
      ALU_ADD: begin
        alu_r  = sum;
        alu_of = (aluA[DW-1] == aluB[DW-1]) && (sum[DW-1] != aluA[DW-1]);
      end
      ALU_SUB: begin
        alu_r  = dif;
        alu_of = (aluA[DW-1] != aluB[DW-1]) && (dif[DW-1] != aluB[DW-1]);
      end
      ALU_AND: alu_r = aluA & aluB;
      ALU_XOR: alu_r = aluA ^ aluB;
`ifdef Y86_EXEC_MULQ_EN
      ALU_MUL: alu_r = mul_done ? mul_p : '0;
`endif
      default: ;
    endcase
    if (!op_ok) alu_r = '0;
  end

  assign e_valE = alu_r;
  assign cc_en  = (E_icode == IOPQ) && op_ok && mul_ok && (E_stat == SAOK) &&
                  !stat_exc(m_stat) && !stat_exc(W_stat);

  // Condition evaluation from the registered flags only.
  always_comb begin
    e_Cnd = 1'b0;
    if (E_icode == IRRMOVQ || E_icode == IJXX) begin
      case (E_ifun)
        C_YES:   e_Cnd = 1'b1;
        C_LE:    e_Cnd = (cc_sf ^ cc_of) | cc_zf;
        C_L:     e_Cnd = cc_sf ^ cc_of;
        C_E:     e_Cnd = cc_zf;
        C_NE:    e_Cnd = ~cc_zf;
        C_GE:    e_Cnd = ~(cc_sf ^ cc_of);
        C_G:     e_Cnd = ~(cc_sf ^ cc_of) & ~cc_zf;
        default: e_Cnd = 1'b0;
      endcase
    end
  end

  assign e_dstE = (E_icode == IRRMOVQ && !e_Cnd) ? RNONE : E_dstE;

  // Condition-code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (cc_en) begin
      cc_zf <= (alu_r == '0);
      cc_sf <= alu_r[DW-1];
      cc_of <= alu_of;
    end
  end

  // E->M register: bubble beats stall; a busy multiplier also inserts bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      M_stat  <= SAOK;
      M_icode <= INOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (M_bubble || (!M_stall && e_busy)) begin
      M_stat  <= SAOK;
      M_icode <= INOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (!M_stall) begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Scoreboard bench for y86_execute_stage: stimulus queues expected values
// tagged with the cycle they must appear; a negedge monitor compares them.
module tb_y86_execute_stage;
  import y86_pkg::*;

  typedef enum int {S_VALE, S_DSTE, S_CND, S_BUSY, S_MSTAT, S_MICODE, S_MCND,
                    S_MVALE, S_MVALA, S_MDSTE, S_MDSTM, S_CC} sig_t;

  typedef struct {
    int unsigned cyc;
    string       name;
    sig_t        sel;
    logic [63:0] exp;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_stall, M_bubble;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
  logic        e_Cnd, e_busy, M_Cnd, cc_zf, cc_sf, cc_of;
  logic [2:0]  M_stat;

  item_t       sb[$];
  int unsigned cycle_cnt = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  y86_execute_stage #(.DW(64), .MUL_BPC(4)) dut (
    .clk(clk), .rst_n(rst_n), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .e_busy(e_busy),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [63:0] read_sig(input sig_t s);
    case (s)
      S_VALE:   return e_valE;
      S_DSTE:   return {60'd0, e_dstE};
      S_CND:    return {63'd0, e_Cnd};
      S_BUSY:   return {63'd0, e_busy};
      S_MSTAT:  return {61'd0, M_stat};
      S_MICODE: return {60'd0, M_icode};
      S_MCND:   return {63'd0, M_Cnd};
      S_MVALE:  return M_valE;
      S_MVALA:  return M_valA;
      S_MDSTE:  return {60'd0, M_dstE};
      S_MDSTM:  return {60'd0, M_dstM};
      default:  return {61'd0, cc_zf, cc_sf, cc_of};
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; overdue ones are failures.
  always @(negedge clk) begin
    int unsigned i;
    item_t it;
    logic [63:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cycle_cnt) begin
        it = sb[i];
        sb.delete(i);
        act = read_sig(it.sel);
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s cycle=%0d actual=%h required=%h", it.name, cycle_cnt, act, it.exp);
        end
      end else if (sb[i].cyc < cycle_cnt) begin
        it = sb[i];
        sb.delete(i);
        checks++;
        failures++;
        $display("FAIL %s not sampled at cycle %0d", it.name, it.cyc);
      end else begin
        i++;
      end
    end
  end

  task automatic exp_at(input int unsigned lat, input string nm, input sig_t s,
                        input logic [63:0] v);
    item_t it;
    it.cyc = cycle_cnt + lat;
    it.name = nm;
    it.sel = s;
    it.exp = v;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] va, input logic [63:0] vb,
                       input logic [63:0] vc, input logic [3:0] de,
                       input logic [3:0] dm);
    E_stat = SAOK; E_icode = ic; E_ifun = fn;
    E_valA = va; E_valB = vb; E_valC = vc; E_dstE = de; E_dstM = dm;
  endtask

  initial begin
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; m_stat = SAOK; W_stat = SAOK;
    issue(INOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
    step();
    exp_at(0, "rst_micode", S_MICODE, 64'(INOP));
    exp_at(0, "rst_mstat",  S_MSTAT,  64'(SAOK));
    exp_at(0, "rst_mdste",  S_MDSTE,  64'hF);
    exp_at(0, "rst_mdstm",  S_MDSTM,  64'hF);
    exp_at(0, "rst_mvale",  S_MVALE,  64'd0);
    exp_at(0, "rst_mcnd",   S_MCND,   64'd0);
    exp_at(0, "rst_cc",     S_CC,     64'b100);
    exp_at(0, "rst_busy",   S_BUSY,   64'd0);
    step(); rst_n = 1'b1;
    // subq 5-7
    issue(IOPQ, 4'd1, 64'd7, 64'd5, 64'd0, 4'd3, RNONE);
    exp_at(0, "sub_vale",   S_VALE,   64'hFFFF_FFFF_FFFF_FFFE);
    exp_at(1, "sub_cc",     S_CC,     64'b010);
    exp_at(1, "sub_mvale",  S_MVALE,  64'hFFFF_FFFF_FFFF_FFFE);
    exp_at(1, "sub_micode", S_MICODE, 64'(IOPQ));
    exp_at(1, "sub_mdste",  S_MDSTE,  64'd3);
    step();
    // cmovl after negative result
    issue(IRRMOVQ, 4'd2, 64'h55, 64'h99, 64'd0, 4'd4, RNONE);
    exp_at(0, "cmovl_cnd",   S_CND,   64'd1);
    exp_at(0, "cmovl_dste",  S_DSTE,  64'd4);
    exp_at(0, "cmovl_vale",  S_VALE,  64'h55);
    exp_at(1, "cmovl_mcnd",  S_MCND,  64'd1);
    exp_at(1, "cmovl_mdste", S_MDSTE, 64'd4);
    step();
    // addq overflow
    issue(IOPQ, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd1, RNONE);
    exp_at(0, "addov_vale", S_VALE, 64'h8000_0000_0000_0000);
    exp_at(1, "addov_cc",   S_CC,   64'b011);
    step();
    // SF=1,OF=1,ZF=0: true result positive, so le false and g true
    issue(IJXX, 4'd1, 64'd0, 64'd0, 64'h40, RNONE, RNONE);
    exp_at(0, "jle_cnd", S_CND, 64'd0);
    step();
    issue(IJXX, 4'd6, 64'd0, 64'd0, 64'h40, RNONE, RNONE);
    exp_at(0, "jg_cnd", S_CND, 64'd1);
    step();
    issue(IOPQ, 4'd2, 64'hF0, 64'h3C, 64'd0, 4'd2, RNONE);
    exp_at(0, "and_vale", S_VALE, 64'h30);
    exp_at(1, "and_cc",   S_CC,   64'b000);
    step();
    issue(IOPQ, 4'd3, 64'h5, 64'h5, 64'd0, 4'd2, RNONE);
    exp_at(0, "xor_vale", S_VALE, 64'd0);
    exp_at(1, "xor_cc",   S_CC,   64'b100);
    step();
    // cmovne with ZF=1 is squashed
    issue(IRRMOVQ, 4'd4, 64'h9, 64'd0, 64'd0, 4'd5, RNONE);
    exp_at(0, "cmovne_cnd",   S_CND,   64'd0);
    exp_at(0, "cmovne_dste",  S_DSTE,  64'hF);
    exp_at(1, "cmovne_mdste", S_MDSTE, 64'hF);
    exp_at(1, "cmovne_mcnd",  S_MCND,  64'd0);
    step();
    issue(IPUSHQ, 4'd0, 64'h1234, 64'h100, 64'd0, 4'd4, RNONE);
    exp_at(0, "push_vale",  S_VALE,  64'hF8);
    exp_at(1, "push_mvale", S_MVALE, 64'hF8);
    exp_at(1, "push_mvala", S_MVALA, 64'h1234);
    step();
    issue(IPOPQ, 4'd0, 64'hF8, 64'hF8, 64'd0, 4'd4, 4'd7);
    exp_at(0, "pop_vale",  S_VALE,  64'h100);
    exp_at(1, "pop_mdstm", S_MDSTM, 64'd7);
    step();
    issue(IMRMOVQ, 4'd0, 64'hAAAA, 64'h20, 64'h10, RNONE, 4'd3);
    exp_at(0, "mrmov_vale", S_VALE, 64'h30);
    step();
    issue(IIRMOVQ, 4'd0, 64'd0, 64'h99, 64'h1234, 4'd6, RNONE);
    exp_at(0, "irmov_vale", S_VALE, 64'h1234);
    step();
    // stall / bubble
    issue(IOPQ, 4'd0, 64'd1, 64'd2, 64'd0, 4'd1, RNONE);
    exp_at(1, "add3_cc", S_CC, 64'b000);
    step();
    M_stall = 1'b1;
    issue(IIRMOVQ, 4'd0, 64'd0, 64'd0, 64'h77, 4'd2, RNONE);
    exp_at(1, "stall_mvale",  S_MVALE,  64'd3);
    exp_at(1, "stall_mdste",  S_MDSTE,  64'd1);
    exp_at(1, "stall_micode", S_MICODE, 64'(IOPQ));
    step();
    M_bubble = 1'b1;
    exp_at(1, "bubble_micode", S_MICODE, 64'(INOP));
    exp_at(1, "bubble_mdste",  S_MDSTE,  64'hF);
    exp_at(1, "bubble_mvale",  S_MVALE,  64'd0);
    step();
    M_stall = 1'b0; M_bubble = 1'b0; m_stat = SADR;
    issue(IOPQ, 4'd1, 64'd4, 64'd4, 64'd0, 4'd1, RNONE);
    exp_at(0, "sadr_vale", S_VALE, 64'd0);
    exp_at(1, "sadr_cc",   S_CC,   64'b000);
    step();
    m_stat = SAOK; W_stat = SHLT;
    issue(IOPQ, 4'd3, 64'd1, 64'd1, 64'd0, 4'd1, RNONE);
    exp_at(1, "whlt_cc", S_CC, 64'b000);
    step();
    W_stat = SAOK;
    issue(IOPQ, 4'd5, 64'd0, 64'd0, 64'd0, 4'd1, RNONE);
    exp_at(1, "badfn_cc", S_CC, 64'b000);
    step();
    issue(IOPQ, 4'd7, 64'd3, 64'd3, 64'd0, 4'd1, RNONE);
    exp_at(0, "badfn_vale", S_VALE, 64'd0);
    step();
`ifndef Y86_EXEC_MULQ_EN
    issue(IOPQ, 4'd4, 64'd2, 64'd3, 64'd0, 4'd1, RNONE);
    exp_at(0, "nomul_vale", S_VALE, 64'd0);
    exp_at(0, "nomul_busy", S_BUSY, 64'd0);
    exp_at(1, "nomul_cc",   S_CC,   64'b000);
    step();
`endif
    issue(IRRMOVQ, 4'd8, 64'd3, 64'd0, 64'd0, 4'd6, RNONE);
    exp_at(0, "cmov8_cnd",  S_CND,  64'd0);
    exp_at(0, "cmov8_dste", S_DSTE, 64'hF);
    step();
    // asynchronous reset in mid-cycle
    issue(IOPQ, 4'd1, 64'd7, 64'd5, 64'd0, 4'd3, RNONE);
    step();
    issue(INOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
    #1 rst_n = 1'b0;
    exp_at(0, "arst_micode", S_MICODE, 64'(INOP));
    exp_at(0, "arst_mdste",  S_MDSTE,  64'hF);
    exp_at(0, "arst_cc",     S_CC,     64'b100);
    step();
    rst_n = 1'b1;
`ifdef Y86_EXEC_MULQ_EN
    step();
    issue(IOPQ, 4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 64'd0, 4'd2, RNONE);
    exp_at(0, "mul_busy0",   S_BUSY,   64'd1);
    exp_at(1, "mul_mbubble", S_MICODE, 64'(INOP));
    for (int k = 0; k < 15; k++) step();
    exp_at(0, "mul_busy15", S_BUSY, 64'd1);
    step();
    exp_at(0, "mul_busyN",   S_BUSY,   64'd0);
    exp_at(0, "mul_vale",    S_VALE,   64'hFFFF_FFFF_FFFF_FFD6);
    exp_at(1, "mul_mvale",   S_MVALE,  64'hFFFF_FFFF_FFFF_FFD6);
    exp_at(1, "mul_micode",  S_MICODE, 64'(IOPQ));
    exp_at(1, "mul_cc",      S_CC,     64'b010);
    step();
    issue(INOP, 4'd0, 64'd0, 64'd0, 64'd0, RNONE, RNONE);
`endif
    for (int k = 0; k < 4; k++) step();
    while (sb.size() > 0) begin
      $display("FAIL %s never compared", sb[0].name);
      void'(sb.pop_front());
      checks++;
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
